// File: rtl/line_fetch_pkg.sv
// Shared definitions for the line fetch engine: FSM state encoding,
// address stride per fetched 16-bit word, and the default FIFO depth.
// No logic; imported by line_fetch and its testbench.
package line_fetch_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t ISSUE    = 3'd1;
    localparam state_t WAIT_ACC = 3'd2;
    localparam state_t WAIT_END = 3'd3;
    localparam state_t HOLD     = 3'd4;
    localparam state_t FINISH   = 3'd5;

    // Byte stride between consecutive 16-bit words.
    localparam logic [31:0] ADDR_STEP = 32'd2;

    localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/line_fetch_sync_fifo.sv
// Purpose: single-clock FIFO with synchronous clear; head word read combinationally.
// Latency: a pushed word is visible at dout/!empty the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, rst_n (async active-low), clr, push/din, pop/dout, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/line_fetch.sv
// Purpose: fetches word_cnt 16-bit words from a single-outstanding memory port into an output FIFO.
// Latency: first out_valid appears bus latency + 3 cycles after start.
// Backpressure: out_valid/out_ready pop; new requests stall in HOLD while the FIFO has no free slot.
// Ports: start/base_addr/word_cnt/abort control, busy/done status, bus_* memory port,
//        out_data/out_valid/out_ready stream output.
module line_fetch
    import line_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             bus_stb,
    output logic             bus_we,
    output logic [31:0]      bus_addr,
    output logic [15:0]      bus_wdata,
    input  logic             bus_sack,
    input  logic             bus_cyc,
    input  logic [15:0]      bus_rdata,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    state_t           state;
    logic [31:0]      addr_reg;
    logic [CNT_W-1:0] remaining;
    logic             stb_q;
    logic             done_q;
    logic             discard;

    logic             fifo_push;
    logic             fifo_clr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             in_flight;
    logic [OW-1:0]    occupancy;
    logic             free_slot;
    logic             cyc_end;

    assign bus_we    = 1'b1;
    assign bus_wdata = 16'h0000;
    assign bus_addr  = addr_reg;
    assign bus_stb   = stb_q;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign out_valid = !fifo_empty;

    // An accepted request reserves its FIFO slot until the word lands.
    assign in_flight = (state == WAIT_ACC) || (state == WAIT_END);
    assign occupancy = OW'(fifo_count) + OW'(in_flight);
    assign free_slot = !fifo_full && (occupancy < OW'(FIFO_DEPTH));

    // The port raises bus_cyc together with bus_sack, so its falling edge
    // in WAIT_END marks read data valid.
    assign cyc_end   = (state == WAIT_END) && !bus_cyc;

    // Data from an aborted cycle is dropped rather than queued.
    assign fifo_push = cyc_end && !discard && !abort;

    always_comb begin
        fifo_clr = 1'b0;
        case (state)
            IDLE:     fifo_clr = start;
            ISSUE:    fifo_clr = abort;
            HOLD:     fifo_clr = abort;
            WAIT_ACC: fifo_clr = abort && !bus_sack;
            WAIT_END: fifo_clr = cyc_end && (discard || abort);
            default:  fifo_clr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            remaining <= '0;
            stb_q     <= 1'b0;
            done_q    <= 1'b0;
            discard   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_reg  <= base_addr;
                        remaining <= word_cnt;
                        discard   <= 1'b0;
                        state     <= (word_cnt == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state <= FINISH;
                    end else if (!bus_cyc && free_slot) begin
                        stb_q <= 1'b1;
                        state <= WAIT_ACC;
                    end else begin
                        state <= HOLD;
                    end
                end
                WAIT_ACC: begin
                    if (bus_sack) begin
                        // Once accepted the cycle must run out; abort only
                        // marks the returning word for disposal.
                        stb_q   <= 1'b0;
                        discard <= abort;
                        state   <= WAIT_END;
                    end else if (abort) begin
                        stb_q <= 1'b0;
                        state <= FINISH;
                    end
                end
                WAIT_END: begin
                    if (abort) discard <= 1'b1;
                    if (!bus_cyc) begin
                        if (discard || abort) begin
                            state <= FINISH;
                        end else begin
                            addr_reg  <= addr_reg + ADDR_STEP;
                            remaining <= remaining - 1'b1;
                            state     <= (remaining == CNT_W'(1)) ? FINISH : ISSUE;
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state <= FINISH;
                    end else if (free_slot && !bus_cyc) begin
                        state <= ISSUE;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    discard <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .din   (bus_rdata),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_line_fetch.sv
// Purpose: directed self-checking bench for line_fetch with a behavioural memory port.
// Latency: port accepts a strobe after sack_delay cycles, holds bus_cyc for 3 cycles.
// Backpressure: out_ready is driven by the directed sequence.
module tb_line_fetch;
    import line_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        abort;
    logic        busy;
    logic        done;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_sack;
    logic        bus_cyc;
    logic [15:0] bus_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    line_fetch #(
        .FIFO_DEPTH (16),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sack  (bus_sack),
        .bus_cyc   (bus_cyc),
        .bus_rdata (bus_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [31:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // Memory port model: sack and cyc rise together, cyc lasts 3 cycles,
    // rdata holds a junk value until cyc falls.
    int          sack_delay;
    int          wait_cnt = 0;
    int          cyc_left = 0;
    bit          in_cycle = 1'b0;
    logic [31:0] acc_addr;
    logic [31:0] addr_log[$];

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus_sack  = 1'b0;
            bus_cyc   = 1'b0;
            bus_rdata = 16'h0000;
            in_cycle  = 1'b0;
            wait_cnt  = 0;
        end else if (!in_cycle) begin
            if (bus_stb && !bus_cyc) begin
                if (wait_cnt >= sack_delay) begin
                    bus_sack  = 1'b1;
                    bus_cyc   = 1'b1;
                    bus_rdata = 16'hDEAD;
                    cyc_left  = 3;
                    in_cycle  = 1'b1;
                    wait_cnt  = 0;
                    acc_addr  = bus_addr;
                    addr_log.push_back(bus_addr);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end else begin
            bus_sack = 1'b0;
            cyc_left--;
            if (cyc_left == 0) begin
                bus_cyc   = 1'b0;
                bus_rdata = word_of(acc_addr);
                in_cycle  = 1'b0;
            end
        end
    end

    // Stream/status monitors, sampled with pre-edge values.
    logic [15:0] got[$];
    int done_cnt   = 0;
    int stb_cycles = 0;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(out_data);
        if (done) done_cnt++;
        if (bus_stb) stb_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [31:0] b, input logic [15:0] c);
        base_addr = b;
        word_cnt  = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int a0;
        int g0;
        int d0;
        int s0;
        int n;

        sack_delay = 0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = 32'h0;
        word_cnt   = 16'h0;
        out_ready  = 1'b1;
        rst_n      = 1'b1;
        #3 rst_n   = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_stb",   {31'd0, bus_stb},   32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr",  bus_addr,           32'h0);
        chk("tie_we",    {31'd0, bus_we},    32'd1);
        chk("tie_wdata", {16'd0, bus_wdata}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Four words, no backpressure.
        a0 = addr_log.size(); g0 = got.size(); d0 = done_cnt;
        launch(32'h0000_1000, 16'd4);
        wait_done(200, "a_done_timeout");
        tick();
        tick();
        chk("a_nreq",  addr_log.size() - a0, 32'd4);
        chk("a_nword", got.size() - g0,      32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_addr%0d", i), addr_log[a0+i], 32'h1000 + 32'(2*i));
            chk($sformatf("a_word%0d", i), {16'd0, got[g0+i]}, {16'd0, word_of(32'h1000 + 32'(2*i))});
        end
        chk("a_done_once", done_cnt - d0, 32'd1);
        chk("a_idle", {31'd0, busy}, 32'd0);

        // Zero-length fetch: done two cycles after start, no bus traffic.
        s0 = stb_cycles; d0 = done_cnt;
        launch(32'h0000_1800, 16'd0);
        chk("z_busy1", {31'd0, busy}, 32'd1);
        chk("z_done1", {31'd0, done}, 32'd0);
        tick();
        chk("z_done2", {31'd0, done}, 32'd1);
        chk("z_busy2", {31'd0, busy}, 32'd0);
        tick();
        chk("z_done3", {31'd0, done}, 32'd0);
        chk("z_nostb", stb_cycles - s0, 32'd0);
        chk("z_once",  done_cnt - d0,   32'd1);

        // Forty words against a stalled consumer: fill exactly to depth, park in HOLD.
        out_ready = 1'b0;
        a0 = addr_log.size(); g0 = got.size();
        launch(32'h0000_2000, 16'd40);
        for (int i = 0; i < 200; i++) tick();
        chk("f_nreq",  addr_log.size() - a0, 32'd16);
        chk("f_hold",  {29'd0, dut.state},   {29'd0, HOLD});
        chk("f_valid", {31'd0, out_valid},   32'd1);
        chk("f_stb",   {31'd0, bus_stb},     32'd0);
        out_ready = 1'b1;
        wait_done(2000, "f_done_timeout");
        tick();
        chk("f_nreq_all",  addr_log.size() - a0, 32'd40);
        chk("f_nword_all", got.size() - g0,      32'd40);
        for (int i = 0; i < 40; i++)
            chk($sformatf("f_word%0d", i), {16'd0, got[g0+i]}, {16'd0, word_of(32'h2000 + 32'(2*i))});

        // Abort while the strobe waits for acceptance.
        sack_delay = 5;
        a0 = addr_log.size();
        launch(32'h0000_3000, 16'd3);
        n = 0;
        while (bus_stb !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("b_stb_up", {31'd0, bus_stb}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("b_stb_drop", {31'd0, bus_stb}, 32'd0);
        tick();
        chk("b_done",  {31'd0, done},      32'd1);
        chk("b_valid", {31'd0, out_valid}, 32'd0);
        chk("b_busy",  {31'd0, busy},      32'd0);
        chk("b_noreq", addr_log.size() - a0, 32'd0);
        sack_delay = 0;
        tick();

        // Abort after acceptance of the second word: cycle runs out, FIFO flushed.
        out_ready = 1'b0;
        a0 = addr_log.size(); g0 = got.size();
        launch(32'h0000_4000, 16'd3);
        n = 0;
        while ((addr_log.size() - a0) < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("c_second_req", addr_log.size() - a0, 32'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_cyc_on",  {31'd0, bus_cyc},   32'd1);
        chk("c_no_done", {31'd0, done},      32'd0);
        chk("c_one_word",{31'd0, out_valid}, 32'd1);
        wait_done(20, "c_done_timeout");
        chk("c_cyc_off", {31'd0, bus_cyc},   32'd0);
        chk("c_flushed", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        chk("c_nreq",   addr_log.size() - a0, 32'd2);
        chk("c_nword",  got.size() - g0,      32'd0);
        out_ready = 1'b1;

        // Address wraps past the top of the 32-bit space.
        a0 = addr_log.size(); g0 = got.size();
        launch(32'hFFFF_FFFE, 16'd2);
        wait_done(100, "w_done_timeout");
        tick();
        chk("w_addr0", addr_log[a0],   32'hFFFF_FFFE);
        chk("w_addr1", addr_log[a0+1], 32'h0000_0000);
        chk("w_word0", {16'd0, got[g0]},   {16'd0, word_of(32'hFFFF_FFFE)});
        chk("w_word1", {16'd0, got[g0+1]}, {16'd0, word_of(32'h0000_0000)});

        // Reset in the middle of a bus cycle, then a normal fetch.
        a0 = addr_log.size();
        launch(32'h0000_5000, 16'd2);
        n = 0;
        while ((addr_log.size() - a0) < 1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("r_in_wait_end", {29'd0, dut.state}, {29'd0, WAIT_END});
        rst_n = 1'b0;
        #1;
        chk("r_busy",  {31'd0, busy},      32'd0);
        chk("r_stb",   {31'd0, bus_stb},   32'd0);
        chk("r_done",  {31'd0, done},      32'd0);
        chk("r_valid", {31'd0, out_valid}, 32'd0);
        chk("r_addr",  bus_addr,           32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        a0 = addr_log.size(); g0 = got.size();
        launch(32'h0000_6000, 16'd2);
        wait_done(100, "r2_done_timeout");
        tick();
        chk("r2_addr0", addr_log[a0],   32'h6000);
        chk("r2_addr1", addr_log[a0+1], 32'h6002);
        chk("r2_word0", {16'd0, got[g0]},   {16'd0, word_of(32'h6000)});
        chk("r2_word1", {16'd0, got[g0+1]}, {16'd0, word_of(32'h6002)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
